// File: rtl/instr_mem_loader_if.sv
// Instruction field input handshake plus instruction-memory write handshake.
// The loader uses the slave modport; whatever feeds it and owns the memory uses master.
interface instr_mem_loader_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_opcode;
    logic       in_rd;
    logic       in_rs;
    logic [2:0] in_imm;
    logic       in_last;

    logic       mem_wr_en;
    logic [7:0] mem_wr_addr;
    logic [7:0] mem_wr_data;
    logic       mem_wr_ready;

    modport master (
        output in_valid, in_opcode, in_rd, in_rs, in_imm, in_last,
        input  in_ready,
        input  mem_wr_en, mem_wr_addr, mem_wr_data,
        output mem_wr_ready
    );

    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs, in_imm, in_last,
        output in_ready,
        output mem_wr_en, mem_wr_addr, mem_wr_data,
        input  mem_wr_ready
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Encodes instruction fields into 8-bit words, buffers them in a small FIFO and
// writes them to consecutive instruction-memory addresses, one session per start.
module instr_mem_loader #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] START_ADDR = 8'd1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    instr_mem_loader_if.slave   bus,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [7:0]          count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [7:0]       FINAL_SLOT = 8'd254;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE,
        ERR
    } state_t;

    state_t           state;
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [LVL_W-1:0] fifo_level;
    logic [7:0]       wr_addr;
    logic [7:0]       count_q;
    logic [7:0]       accepted;
    logic             error_q;

    logic [7:0] in_word;
    logic       opcode_legal;
    logic       fifo_full;
    logic       fifo_empty;
    logic       active;
    logic       in_ready_int;
    logic       wr_en_int;
    logic       in_fire;
    logic       push;
    logic       pop;
    logic       final_word;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign in_word      = {bus.in_opcode, bus.in_rd, bus.in_rs, bus.in_imm};
    assign opcode_legal = (bus.in_opcode == 3'b000) || bus.in_opcode[2];
    assign fifo_full    = (fifo_level == FULL_LEVEL);
    assign fifo_empty   = (fifo_level == '0);
    assign active       = (state == LOAD) || (state == DRAIN);

    // Handshake enables are qualified by rst_n so nothing transfers in a reset cycle.
    assign in_ready_int = rst_n && (state == LOAD) && !fifo_full;
    assign wr_en_int    = rst_n && active && !fifo_empty;
    assign in_fire      = bus.in_valid && in_ready_int;
    assign push         = in_fire && opcode_legal;
    assign pop          = wr_en_int && bus.mem_wr_ready;
    assign final_word   = (accepted == FINAL_SLOT);

    assign bus.in_ready    = in_ready_int;
    assign bus.mem_wr_en   = wr_en_int;
    assign bus.mem_wr_addr = wr_en_int ? wr_addr : 8'd0;
    assign bus.mem_wr_data = wr_en_int ? fifo_mem[rd_ptr] : 8'd0;

    assign busy  = rst_n && active;
    assign done  = rst_n && (state == DONE);
    assign error = rst_n && error_q;
    assign count = count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_word;
        end
    end

    // Later assignments in this block deliberately override the FIFO bookkeeping
    // above them when a session restarts or an illegal opcode flushes the buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_level <= '0;
            wr_addr    <= START_ADDR;
            count_q    <= 8'd0;
            accepted   <= 8'd0;
            error_q    <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr  <= next_ptr(rd_ptr);
                wr_addr <= wr_addr + 8'd1;
                count_q <= count_q + 8'd1;
            end
            if (push) begin
                wr_ptr   <= next_ptr(wr_ptr);
                accepted <= accepted + 8'd1;
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + 1'b1;
            end else if (!push && pop) begin
                fifo_level <= fifo_level - 1'b1;
            end

            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state      <= LOAD;
                        wr_addr    <= START_ADDR;
                        count_q    <= 8'd0;
                        accepted   <= 8'd0;
                        error_q    <= 1'b0;
                        rd_ptr     <= '0;
                        wr_ptr     <= '0;
                        fifo_level <= '0;
                    end else if (state == DONE) begin
                        state <= IDLE;
                    end
                end
                LOAD: begin
                    if (in_fire) begin
                        if (!opcode_legal) begin
                            state      <= ERR;
                            error_q    <= 1'b1;
                            rd_ptr     <= '0;
                            wr_ptr     <= '0;
                            fifo_level <= '0;
                        end else if (bus.in_last || final_word) begin
                            state <= DRAIN;
                            // A session cut off at 255 words without in_last is an overflow.
                            if (!bus.in_last) begin
                                error_q <= 1'b1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized scoreboard bench for instr_mem_loader: stimulus pushes expected
// memory writes, an independent monitor pops and compares them.
module tb_instr_mem_loader;

    localparam logic [7:0] START = 8'd1;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] count;

    instr_mem_loader_if mif ();

    instr_mem_loader #(
        .FIFO_DEPTH (4),
        .START_ADDR (START)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bus   (mif),
        .busy  (busy),
        .done  (done),
        .error (error),
        .count (count)
    );

    int          num_checks      = 0;
    int          num_miscompares = 0;
    logic [15:0] exp_q[$];
    int          sess_words      = 0;
    int          ready_mode      = 0;
    logic [2:0]  legal_ops [5]   = '{3'b000, 3'b100, 3'b101, 3'b110, 3'b111};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_miscompares++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit is_legal(input logic [2:0] op);
        return op inside {3'b000, 3'b100, 3'b101, 3'b110, 3'b111};
    endfunction

    // Offers one word until accepted; legal words become expected writes in order.
    task automatic applyStimulus(input logic [2:0] op, input logic rd, input logic rs,
                                 input logic [2:0] imm, input logic last);
        bit acc = 0;
        int budget = 0;
        @(negedge clk);
        mif.in_opcode = op;
        mif.in_rd     = rd;
        mif.in_rs     = rs;
        mif.in_imm    = imm;
        mif.in_last   = last;
        mif.in_valid  = 1'b1;
        while (!acc && budget < 2000) begin
            #1;
            acc = mif.in_ready;
            @(posedge clk);
            if (!acc) begin
                budget++;
                @(negedge clk);
            end
        end
        if (!acc) begin
            checkOutput("accept_timeout", 32'(acc), 32'd1);
        end else if (is_legal(op)) begin
            exp_q.push_back({8'(START + 8'(sess_words)), op, rd, rs, imm});
            sess_words++;
        end
        @(negedge clk);
        mif.in_valid = 1'b0;
    endtask

    task automatic apply_random(input logic last);
        applyStimulus(legal_ops[$urandom_range(0, 4)], 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), last);
    endtask

    task automatic start_session();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sess_words = 0;
    endtask

    task automatic wait_done(input int exp_count, input logic exp_err);
        bit seen = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            #3;
            if (done) begin
                seen = 1;
                break;
            end
        end
        checkOutput("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            checkOutput("done_count", 32'(count), 32'(exp_count));
            checkOutput("done_error", 32'(error), 32'(exp_err));
            checkOutput("done_busy", 32'(busy), 32'd0);
            checkOutput("pending_writes", 32'(exp_q.size()), 32'd0);
            @(negedge clk);
            #3;
            checkOutput("done_pulse", 32'(done), 32'd0);
            checkOutput("count_hold", 32'(count), 32'(exp_count));
        end
        exp_q.delete();
    endtask

    task automatic check_quiet(input string tag);
        checkOutput({tag, "_in_ready"}, 32'(mif.in_ready), 32'd0);
        checkOutput({tag, "_wr_en"}, 32'(mif.mem_wr_en), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_error"}, 32'(error), 32'd0);
        checkOutput({tag, "_addr"}, 32'(mif.mem_wr_addr), 32'd0);
        checkOutput({tag, "_data"}, 32'(mif.mem_wr_data), 32'd0);
    endtask

    initial begin
        mif.mem_wr_ready = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            case (ready_mode)
                0:       mif.mem_wr_ready = 1'b0;
                1:       mif.mem_wr_ready = 1'b1;
                default: mif.mem_wr_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: every completed write must match the scoreboard head; a stalled
    // write must hold address and data until it completes.
    initial begin
        logic        hold_pending = 1'b0;
        logic [7:0]  hold_addr = 8'd0;
        logic [7:0]  hold_data = 8'd0;
        logic [15:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                hold_pending = 1'b0;
            end else begin
                if (hold_pending) begin
                    checkOutput("hold_en", 32'(mif.mem_wr_en), 32'd1);
                    checkOutput("hold_addr", 32'(mif.mem_wr_addr), 32'(hold_addr));
                    checkOutput("hold_data", 32'(mif.mem_wr_data), 32'(hold_data));
                end
                if (mif.mem_wr_en && mif.mem_wr_ready) begin
                    if (exp_q.size() == 0) begin
                        num_checks++;
                        num_miscompares++;
                        $display("[TB] FAIL unexpected_write actual=%0h@%0h expected=none at %0t",
                                 mif.mem_wr_data, mif.mem_wr_addr, $time);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("wr_addr", 32'(mif.mem_wr_addr), 32'(e[15:8]));
                        checkOutput("wr_data", 32'(mif.mem_wr_data), 32'(e[7:0]));
                    end
                end
                hold_pending = mif.mem_wr_en && !mif.mem_wr_ready;
                hold_addr    = mif.mem_wr_addr;
                hold_data    = mif.mem_wr_data;
            end
        end
    end

    initial begin
        int n;
        rst_n        = 1'b0;
        start        = 1'b0;
        mif.in_valid = 1'b0;
        mif.in_opcode = 3'b000;
        mif.in_rd    = 1'b0;
        mif.in_rs    = 1'b0;
        mif.in_imm   = 3'b000;
        mif.in_last  = 1'b0;

        repeat (2) @(negedge clk);
        #3;
        check_quiet("reset");
        checkOutput("reset_count", 32'(count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #3;
        check_quiet("post_reset");

        $display("[TB] basic load");
        ready_mode = 1;
        start_session();
        applyStimulus(3'b000, 1'b1, 1'b0, 3'b000, 1'b0);
        applyStimulus(3'b100, 1'b0, 1'b0, 3'b111, 1'b0);
        applyStimulus(3'b101, 1'b0, 1'b1, 3'b100, 1'b1);
        wait_done(3, 1'b0);

        $display("[TB] backpressure");
        ready_mode = 0;
        start_session();
        for (int i = 0; i < 4; i++) apply_random(1'b0);
        #1;
        checkOutput("bp_in_ready_full", 32'(mif.in_ready), 32'd0);
        checkOutput("bp_busy", 32'(busy), 32'd1);
        repeat (4) @(negedge clk);
        ready_mode = 1;
        apply_random(1'b1);
        wait_done(5, 1'b0);

        $display("[TB] illegal opcode");
        start_session();
        applyStimulus(3'b110, 1'b1, 1'b0, 3'b100, 1'b0);
        repeat (3) @(negedge clk);
        applyStimulus(3'b010, 1'b1, 1'b1, 3'b001, 1'b0);
        #3;
        checkOutput("err_error", 32'(error), 32'd1);
        checkOutput("err_in_ready", 32'(mif.in_ready), 32'd0);
        checkOutput("err_busy", 32'(busy), 32'd0);
        checkOutput("err_wr_en", 32'(mif.mem_wr_en), 32'd0);
        repeat (5) @(negedge clk);
        #3;
        checkOutput("err_sticky", 32'(error), 32'd1);
        start_session();
        #3;
        checkOutput("err_cleared", 32'(error), 32'd0);
        checkOutput("restart_busy", 32'(busy), 32'd1);
        apply_random(1'b1);
        wait_done(1, 1'b0);

        $display("[TB] overflow");
        ready_mode = 2;
        start_session();
        for (int i = 0; i < 255; i++) apply_random(1'b0);
        #1;
        checkOutput("ovf_in_ready", 32'(mif.in_ready), 32'd0);
        checkOutput("ovf_busy", 32'(busy), 32'd1);
        wait_done(255, 1'b1);

        $display("[TB] reset mid-session");
        ready_mode = 0;
        start_session();
        apply_random(1'b0);
        apply_random(1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #3;
        checkOutput("rst_cycle_wr_en", 32'(mif.mem_wr_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        #3;
        checkOutput("rst_wr_en", 32'(mif.mem_wr_en), 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        ready_mode = 1;
        start_session();
        apply_random(1'b1);
        wait_done(1, 1'b0);

        $display("[TB] start during load");
        ready_mode = 2;
        start_session();
        apply_random(1'b0);
        apply_random(1'b0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        apply_random(1'b0);
        apply_random(1'b1);
        wait_done(4, 1'b0);

        $display("[TB] random sessions");
        for (int s = 0; s < 4; s++) begin
            start_session();
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                apply_random(1'(i == n - 1));
            end
            wait_done(n, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_miscompares);
        $finish;
    end

endmodule
